johnson_sequence_monitor: RTL and testbench

Downstream consumer of the 4-bit twisted-ring (Johnson) counter. Each cycle it samples the counter's output word and decodes it to a 3-bit phase. It checks that the word is a legal Johnson code and that it advances by exactly one phase per clock. It reports lock status, flags errors with one-cycle pulses, and counts completed revolutions.

---
 rtl/johnson_sequence_monitor.sv | 116 +++++++++++
 tb/tb_johnson_sequence_monitor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/johnson_sequence_monitor.sv
// johnson_sequence_monitor: checks a 4-bit Johnson counter word for legal codes and +1-per-clock stepping
// Ports: clk, sync_reset (sync, active-high); johnson_in upstream word; phase/phase_valid decoded phase;
// locked after LOCK_COUNT consecutive +1 steps; illegal_code/seq_error one-cycle pulses;
// rev_count counts 7->0 steps while locked; err_count (only with JSM_ERR_COUNT_EN) saturating error count.
module johnson_sequence_monitor #(
  parameter int REV_WIDTH = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic [3:0]           johnson_in,
  output logic [2:0]           phase,
  output logic                 phase_valid,
  output logic                 locked,
  output logic                 illegal_code,
  output logic                 seq_error,
`ifdef JSM_ERR_COUNT_EN
  output logic [7:0]           err_count,
`endif
  output logic [REV_WIDTH-1:0] rev_count
);
  typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED} state_t;
  state_t     state;
  logic [3:0] in_q;
  logic       in_v;
  logic [3:0] good_cnt;
  logic [2:0] prev_phase;
  logic [2:0] dec;
  logic       legal;
  logic       step_p1;
  logic       step_hold;
  logic       ill_n;
  logic       seq_n;
  always_comb begin
    legal = 1'b1;
    dec = 3'd0;
    case (in_q)
      4'b0000: dec = 3'd0;
      4'b0001: dec = 3'd1;
      4'b0011: dec = 3'd2;
      4'b0111: dec = 3'd3;
      4'b1111: dec = 3'd4;
      4'b1110: dec = 3'd5;
      4'b1100: dec = 3'd6;
      4'b1000: dec = 3'd7;
      default: legal = 1'b0;
    endcase
  end
  assign step_p1 = dec == prev_phase + 3'd1;
  assign step_hold = dec == prev_phase;
  // ACQUIRE accepts any legal word without a step check, so skips only count once tracking
  assign ill_n = in_v && !legal;
  assign seq_n = in_v && legal && !step_p1 && !step_hold && state != ACQUIRE;
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state <= ACQUIRE;
      in_q <= 4'd0;
      in_v <= 1'b0;
      good_cnt <= 4'd0;
      prev_phase <= 3'd0;
      phase <= 3'd0;
      phase_valid <= 1'b0;
      locked <= 1'b0;
      illegal_code <= 1'b0;
      seq_error <= 1'b0;
      rev_count <= '0;
    end else begin
      in_q <= johnson_in;
      in_v <= 1'b1;
      illegal_code <= ill_n;
      seq_error <= seq_n;
      if (ill_n) begin
        state <= ACQUIRE;
        phase_valid <= 1'b0;
        locked <= 1'b0;
      end else if (in_v) begin
        phase <= dec;
        prev_phase <= dec;
        phase_valid <= 1'b1;
        case (state)
          ACQUIRE: begin
            state <= TRACK;
            good_cnt <= 4'd0;
          end
          TRACK: begin
            if (step_p1) begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 == 4'(LOCK_COUNT)) begin
                state <= LOCKED;
                locked <= 1'b1;
              end
            end else if (seq_n)
              good_cnt <= 4'd0;
          end
          default: begin
            if (step_p1 && prev_phase == 3'd7)
              rev_count <= rev_count + REV_WIDTH'(1);
            else if (seq_n) begin
              state <= TRACK;
              good_cnt <= 4'd0;
              locked <= 1'b0;
            end
          end
        endcase
      end
    end
  end
`ifdef JSM_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (sync_reset)
      err_count <= 8'd0;
    else if ((ill_n || seq_n) && err_count != 8'hff)
      err_count <= err_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_johnson_sequence_monitor.sv
// tb_johnson_sequence_monitor: directed and random stimulus against a sample-level reference model
module tb_johnson_sequence_monitor;
  logic       clk = 1'b0;
  logic       sync_reset = 1'b1;
  logic [3:0] johnson_in = 4'd0;
  logic [2:0] phase, phase2;
  logic       phase_valid, phase_valid2, locked, locked2;
  logic       illegal_code, illegal_code2, seq_error, seq_error2;
  logic [7:0] rev_count;
  logic [1:0] rev_count2;
`ifdef JSM_ERR_COUNT_EN
  logic [7:0] err_count, err_count2;
`endif
  int n_tests = 0;
  int n_fail = 0;
  logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
  logic [3:0] bad [8] = '{4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1011, 4'b1101};
  int m_mode, m_good, m_prev, m_phase, m_pv, m_ill, m_seq, m_rev, m_err;
  logic [3:0] pend_w;
  int pend_v;
  int cp;
  always #5 clk = ~clk;
  johnson_sequence_monitor dut (
    .clk(clk), .sync_reset(sync_reset), .johnson_in(johnson_in),
    .phase(phase), .phase_valid(phase_valid), .locked(locked),
    .illegal_code(illegal_code), .seq_error(seq_error),
`ifdef JSM_ERR_COUNT_EN
    .err_count(err_count),
`endif
    .rev_count(rev_count)
  );
  johnson_sequence_monitor #(.REV_WIDTH(2)) dut2 (
    .clk(clk), .sync_reset(sync_reset), .johnson_in(johnson_in),
    .phase(phase2), .phase_valid(phase_valid2), .locked(locked2),
    .illegal_code(illegal_code2), .seq_error(seq_error2),
`ifdef JSM_ERR_COUNT_EN
    .err_count(err_count2),
`endif
    .rev_count(rev_count2)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int find_phase(input logic [3:0] w);
    for (int i = 0; i < 8; i++)
      if (codes[i] == w) return i;
    return -1;
  endfunction
  task automatic model_reset();
    {m_mode, m_good, m_prev, m_phase, m_pv, m_ill, m_seq, m_rev, m_err} = '0;
    pend_v = 0;
  endtask
  // mode: 0 acquiring, 1 tracking, 2 locked
  task automatic model_step(input logic [3:0] w);
    int d;
    d = find_phase(w);
    m_ill = 0;
    m_seq = 0;
    if (d < 0) begin
      m_ill = 1;
      m_pv = 0;
      m_mode = 0;
    end else begin
      if (m_mode == 0) begin
        m_mode = 1;
        m_good = 0;
      end else if (d == (m_prev + 1) % 8) begin
        if (m_mode == 1) begin
          m_good++;
          if (m_good == 4) m_mode = 2;
        end else if (m_prev == 7)
          m_rev++;
      end else if (d != m_prev) begin
        m_seq = 1;
        m_good = 0;
        m_mode = 1;
      end
      m_phase = d;
      m_prev = d;
      m_pv = 1;
    end
    if ((m_ill || m_seq) && m_err < 255) m_err++;
  endtask
  task automatic compare_all();
    check("phase", phase, m_phase);
    check("phase_valid", phase_valid, m_pv);
    check("locked", locked, m_mode == 2);
    check("illegal_code", illegal_code, m_ill);
    check("seq_error", seq_error, m_seq);
    check("rev_count", rev_count, m_rev % 256);
    check("rev_count_w2", rev_count2, m_rev % 4);
    check("locked_w2", locked2, m_mode == 2);
    check("pulse_excl", illegal_code & seq_error, 0);
`ifdef JSM_ERR_COUNT_EN
    check("err_count", err_count, m_err);
    check("err_count_w2", err_count2, m_err);
`endif
  endtask
  task automatic tick(input logic [3:0] w, input logic rst_i);
    johnson_in = w;
    sync_reset = rst_i;
    @(posedge clk);
    #1;
    if (rst_i) model_reset();
    else begin
      m_ill = 0;
      m_seq = 0;
      if (pend_v != 0) model_step(pend_w);
      pend_w = w;
      pend_v = 1;
    end
    compare_all();
  endtask
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      cp = (cp + 1) % 8;
      tick(codes[cp], 1'b0);
    end
  endtask
  task automatic restart();
    tick(4'd0, 1'b1);
    cp = 0;
    tick(codes[0], 1'b0);
  endtask
  initial begin
    model_reset();
    restart();
    check("pv_after_one_edge", phase_valid, 0);
    tick(codes[0], 1'b0);
    tick(codes[0], 1'b0);
    check("pv_two_edges", phase_valid, 1);
    check("hold0_no_err", illegal_code | seq_error, 0);
    adv(4);
    check("not_locked_yet", locked, 0);
    adv(1);
    check("locked_4_steps", locked, 1);
    adv(5);
    tick(4'b0101, 1'b0);
    tick(codes[cp], 1'b0);
    check("ill_pulse", illegal_code, 1);
    check("ill_unlock", locked, 0);
    check("ill_pv", phase_valid, 0);
    adv(1);
    check("ill_pulse_once", illegal_code, 0);
    adv(8);
    check("relock_ill", locked, 1);
    while (cp != 2) adv(1);
    cp = 4;
    tick(codes[cp], 1'b0);
    adv(1);
    check("seq_pulse", seq_error, 1);
    check("seq_unlock", locked, 0);
    adv(4);
    check("relock_seq", locked, 1);
    while (cp != 3) adv(1);
    for (int i = 0; i < 3; i++) tick(codes[3], 1'b0);
    tick(codes[3], 1'b0);
    check("hold_phase", phase, 3);
    check("hold_locked", locked, 1);
    restart();
    adv(33);
    check("rev4", rev_count, 4);
    check("rev_wrap_w2", rev_count2, 0);
    adv(8);
    check("rev5", rev_count, 5);
    tick(codes[cp], 1'b1);
    check("rst_rev", rev_count, 0);
    check("rst_locked", locked, 0);
    check("rst_pv", phase_valid, 0);
    check("rst_phase", phase, 0);
    for (int i = 0; i < 300; i++) tick(bad[i % 8], 1'b0);
    tick(codes[0], 1'b0);
`ifdef JSM_ERR_COUNT_EN
    check("err_sat", err_count, 255);
`endif
    restart();
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 5) restart();
      else if (r < 700) adv(1);
      else if (r < 820) tick(codes[cp], 1'b0);
      else if (r < 900) begin
        cp = (cp + 2 + $urandom_range(0, 5)) % 8;
        tick(codes[cp], 1'b0);
      end else
        tick(bad[$urandom_range(0, 7)], 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
